// File: rtl/rv32i_fetch_queue_pkg.sv
// rv32i_fetch_queue_pkg: shared FSM encodings and default boot pc for the fetch queue slice.
package rv32i_fetch_queue_pkg;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/rv32i_sync_fifo.sv
// rv32i_sync_fifo: power-of-two synchronous FIFO with flush; head entry is registered storage.
module rv32i_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    // Flush overrides both push and pop; popping an empty queue is a no-op.
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(do_push && count == CW'(DEPTH)));

endmodule

// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue: consumer side of the prefetch interface; boot/redirect FSM, credit-based
// fetch issue and a small {pc, instr} FIFO presented to decode via valid/ready.
module rv32i_fetch_queue
    import rv32i_fetch_queue_pkg::*;
#(
    parameter  int              XLEN     = 32,
    parameter  int              ILEN     = 32,
    parameter  int              DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    localparam int              CW       = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            advance_o,
    output logic            pc_write_o,
    output logic [XLEN-1:0] pc_target_o,
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic [ILEN-1:0] fetch_instr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [CW-1:0]   count_o
);

    state_t                 state_q, state_d;
    logic                   inflight_q, keep_q;
    logic                   boot, credit, push;
    logic [XLEN+ILEN-1:0]   head;

    assign boot = state_q == S_BOOT;
    // Credit counts in-flight fetches so the queue can never overflow without looking at ready.
    assign credit = ({1'b0, count_o} + (CW + 1)'(inflight_q)) < (CW + 1)'(DEPTH);

    always_comb begin
        state_d     = boot ? S_RUN : state_q;
        pc_write_o  = rst_ni & (boot | redirect_i);
        advance_o   = rst_ni & (boot | redirect_i | credit);
        pc_target_o = (boot & ~redirect_i) ? RESET_PC : redirect_pc_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_BOOT;
            inflight_q <= 1'b0;
            keep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= advance_o;
            keep_q     <= advance_o;
        end
    end

    // An arrival coinciding with a redirect belongs to the old stream and is dropped.
    assign push = inflight_q & keep_q & ~redirect_i;

    rv32i_sync_fifo #(
        .WIDTH(XLEN + ILEN),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (push),
        .pop   (instr_ready_i),
        .flush (redirect_i),
        .wdata ({fetch_pc_i, fetch_instr_i}),
        .rdata (head),
        .count (count_o)
    );

    assign instr_valid_o   = count_o != '0;
    assign {pc_o, instr_o} = head;

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// tb_rv32i_fetch_queue: table-driven checks of boot, backpressure and redirect behaviour,
// plus hand sequences for async reset and a DEPTH=2 build.
module tb_rv32i_fetch_queue;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rst2_n = 1'b0;
    logic        advance, pc_write, redirect = 1'b0, ready = 1'b0, valid;
    logic [31:0] target, fpc, finstr, rpc = '0, instr, pc, seq;
    logic [2:0]  count;
    logic        advance2, pc_write2, valid2;
    logic [31:0] target2, fpc2, finstr2, instr2, pc2, seq2;
    logic [1:0]  count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32i_fetch_queue dut (
        .clk_i(clk), .rst_ni(rst_ni), .advance_o(advance), .pc_write_o(pc_write),
        .pc_target_o(target), .fetch_pc_i(fpc), .fetch_instr_i(finstr),
        .redirect_i(redirect), .redirect_pc_i(rpc), .instr_valid_o(valid),
        .instr_ready_i(ready), .instr_o(instr), .pc_o(pc), .count_o(count)
    );

    rv32i_fetch_queue #(.DEPTH(2)) dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .advance_o(advance2), .pc_write_o(pc_write2),
        .pc_target_o(target2), .fetch_pc_i(fpc2), .fetch_instr_i(finstr2),
        .redirect_i(1'b0), .redirect_pc_i(32'h0), .instr_valid_o(valid2),
        .instr_ready_i(1'b1), .instr_o(instr2), .pc_o(pc2), .count_o(count2)
    );

    // Prefetch models: one-cycle return, pc-write loads target else sequential pc.
    always @(posedge clk) begin
        if (advance) begin
            fpc <= pc_write ? target : seq;
            seq <= (pc_write ? target : seq) + 32'd4;
        end
        if (advance2) begin
            fpc2 <= pc_write2 ? target2 : seq2;
            seq2 <= (pc_write2 ? target2 : seq2) + 32'd4;
        end
    end
    assign finstr  = fpc ^ MASK;
    assign finstr2 = fpc2 ^ MASK;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          v;
        logic [31:0] pc;
        logic [2:0]  cnt;
        bit          adv;
        bit          pcw;
        logic [31:0] tgt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit rd, input bit re, input logic [31:0] rp,
                       input bit v, input logic [31:0] p, input logic [2:0] c,
                       input bit a, input bit w, input logic [31:0] t);
        vec_t x;
        x.rst = r; x.rdy = rd; x.redir = re; x.rpc = rp; x.v = v; x.pc = p;
        x.cnt = c; x.adv = a; x.pcw = w; x.tgt = t;
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0; ready = 1'b0; redirect = 1'b0; rpc = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        // Stream from boot with ready high.
        add(1,1,0,0,       0,0,0,1,1,0);
        add(0,1,0,0,       0,0,0,1,0,0);
        add(0,1,0,0,       1,0,1,1,0,0);
        add(0,1,0,0,       1,4,1,1,0,0);
        add(0,1,0,0,       1,8,1,1,0,0);
        add(0,1,0,0,       1,12,1,1,0,0);
        // Backpressure: fill to DEPTH, then drain in order.
        add(1,0,0,0,       0,0,0,1,1,0);
        add(0,0,0,0,       0,0,0,1,0,0);
        add(0,0,0,0,       1,0,1,1,0,0);
        add(0,0,0,0,       1,0,2,1,0,0);
        add(0,0,0,0,       1,0,3,0,0,0);
        add(0,0,0,0,       1,0,4,0,0,0);
        add(0,0,0,0,       1,0,4,0,0,0);
        add(0,1,0,0,       1,0,4,0,0,0);
        add(0,1,0,0,       1,4,3,1,0,0);
        add(0,1,0,0,       1,8,2,1,0,0);
        add(0,1,0,0,       1,12,2,1,0,0);
        add(0,1,0,0,       1,16,2,1,0,0);
        add(0,1,0,0,       1,20,2,1,0,0);
        // Redirect with count=3 and a fetch in flight.
        add(1,0,0,0,       0,0,0,1,1,0);
        add(0,0,0,0,       0,0,0,1,0,0);
        add(0,0,0,0,       1,0,1,1,0,0);
        add(0,0,0,0,       1,0,2,1,0,0);
        add(0,0,1,32'h40,  1,0,3,1,1,32'h40);
        add(0,0,0,0,       0,0,0,1,0,0);
        add(0,1,0,0,       1,32'h40,1,1,0,0);
        add(0,1,0,0,       1,32'h44,1,1,0,0);
        add(0,1,0,0,       1,32'h48,1,1,0,0);
        // Redirect with ready, then back-to-back second redirect.
        add(1,1,0,0,       0,0,0,1,1,0);
        add(0,1,0,0,       0,0,0,1,0,0);
        add(0,1,0,0,       1,0,1,1,0,0);
        add(0,1,1,32'h40,  1,4,1,1,1,32'h40);
        add(0,1,1,32'h80,  0,0,0,1,1,32'h80);
        add(0,1,0,0,       0,0,0,1,0,0);
        add(0,1,0,0,       1,32'h80,1,1,0,0);
        add(0,1,0,0,       1,32'h84,1,1,0,0);
        // Redirect during the boot cycle overrides RESET_PC.
        add(1,1,1,32'h100, 0,0,0,1,1,32'h100);
        add(0,1,0,0,       0,0,0,1,0,0);
        add(0,1,0,0,       1,32'h100,1,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            else @(negedge clk);
            ready = tbl[i].rdy; redirect = tbl[i].redir; rpc = tbl[i].rpc;
            #1;
            chk($sformatf("v%0d valid", i), 32'(valid), 32'(tbl[i].v));
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d advance", i), 32'(advance), 32'(tbl[i].adv));
            chk($sformatf("v%0d pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
            if (tbl[i].pcw) chk($sformatf("v%0d target", i), target, tbl[i].tgt);
            if (tbl[i].v) begin
                chk($sformatf("v%0d pc", i), pc, tbl[i].pc);
                chk($sformatf("v%0d instr", i), instr, tbl[i].pc ^ MASK);
            end
        end

        // Async reset pulse mid-stream with count=2.
        do_reset();
        repeat (3) @(negedge clk);
        #1 chk("rst pre count", 32'(count), 32'd2);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst advance", 32'(advance), 32'd0);
        chk("rst pc_write", 32'(pc_write), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("reboot advance", 32'(advance), 32'd1);
        chk("reboot pc_write", 32'(pc_write), 32'd1);
        chk("reboot target", target, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("reboot valid", 32'(valid), 32'd1);
        chk("reboot pc", pc, 32'd0);
        chk("reboot count", 32'(count), 32'd1);

        // DEPTH=2 build streaming with ready held high.
        begin
            logic [31:0] exp_pc;
            int delivered;
            exp_pc = '0;
            delivered = 0;
            @(negedge clk);
            rst2_n = 1'b1;
            for (int c = 0; c < 40; c++) begin
                #1;
                if (valid2) begin
                    chk("d2 pc", pc2, exp_pc);
                    chk("d2 instr", instr2, exp_pc ^ MASK);
                    exp_pc += 32'd4;
                    delivered++;
                end
                @(negedge clk);
            end
            chk("d2 throughput", 32'(delivered >= 18), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
